// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_writeback_pkg
// Brief  : Shared constants, types and helpers for the regfile write-back path.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_writeback_pkg;

    localparam int REG_W    = 5;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'b00000;

    // Which producer won the single push slot this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_writeback_if
// Brief  : ALU and load-unit result channels (valid/ready) into the write-back.
// Rev    : 1.0  initial release
// ============================================================================
interface regfile_writeback_if
    import regfile_writeback_pkg::*;
#(
    parameter int ADDR_W = REG_W,
    parameter int DATA_W = XLEN
) ();

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready
    );

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_fifo
// Brief  : Small result FIFO; exposes every entry in age order for forwarding.
// Rev    : 1.0  initial release
// ============================================================================
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_W,
    parameter int DATA_W = XLEN,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_CNT_W = c_PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [c_CNT_W-1:0]            count,
    output logic [DEPTH-1:0][ADDR_W-1:0]  age_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]  age_data,
    output logic [DEPTH-1:0]              age_valid
);

    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still take a push
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_addr[r_wr_ptr] <= push_addr;
            r_mem_data[r_wr_ptr] <= push_data;
        end
    end

    // Slot 0 is the head (oldest); higher slots are progressively younger
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [c_PTR_W-1:0] w_idx;
        assign w_idx         = r_rd_ptr + c_PTR_W'(gi);
        assign age_addr[gi]  = r_mem_addr[w_idx];
        assign age_data[gi]  = r_mem_data[w_idx];
        assign age_valid[gi] = (c_CNT_W'(gi) < r_count);
    end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module : regfile_writeback
// Brief  : Regfile write-side front end: arbitration, FIFO drain, pending
//          scoreboard and forwarding lookup.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_W,
    parameter int DATA_W = XLEN,
    localparam int c_CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_writeback_if.slave   wb,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    input  logic [ADDR_W-1:0]    fwd_addr,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data,
    output logic                 write_reg,
    output logic [ADDR_W-1:0]    dstreg_addr,
    output logic [DATA_W-1:0]    dstreg_data,
    output logic [NUM_REGS-1:0]  pending,
    output logic [c_CNT_W-1:0]   fifo_count
);

    logic                         w_full;
    logic                         w_empty;
    logic [DEPTH-1:0][ADDR_W-1:0] w_age_addr;
    logic [DEPTH-1:0][DATA_W-1:0] w_age_data;
    logic [DEPTH-1:0]             w_age_valid;

    wb_src_e           w_src;
    logic              w_push;
    logic [ADDR_W-1:0] w_push_addr;
    logic [DATA_W-1:0] w_push_data;

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    // Readiness looks only at the pre-pop occupancy; the load unit has priority
    assign wb.mem_ready = !w_full;
    assign wb.alu_ready = !w_full && !wb.mem_valid;

    always_comb begin
        w_src       = SRC_NONE;
        w_push_addr = '0;
        w_push_data = '0;
        if (wb.mem_valid && wb.mem_ready) begin
            w_src       = SRC_MEM;
            w_push_addr = wb.mem_addr;
            w_push_data = wb.mem_data;
        end else if (wb.alu_valid && wb.alu_ready) begin
            w_src       = SRC_ALU;
            w_push_addr = wb.alu_addr;
            w_push_data = wb.alu_data;
        end
    end

    // Writes to r0 complete the handshake but are dropped here
    assign w_push = (w_src != SRC_NONE) && (w_push_addr != REG_ZERO);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_addr (w_push_addr),
        .push_data (w_push_data),
        .pop       (write_reg),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count),
        .age_addr  (w_age_addr),
        .age_data  (w_age_data),
        .age_valid (w_age_valid)
    );

    assign write_reg   = !w_empty;
    assign dstreg_addr = w_empty ? '0 : w_age_addr[0];
    assign dstreg_data = w_empty ? '0 : w_age_data[0];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && (issue_addr != REG_ZERO)) w_set = reg_onehot(issue_addr);
        if (write_reg)                               w_clr = reg_onehot(dstreg_addr);
    end

    // Set is applied after clear so a same-cycle issue to the draining register wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & ~NUM_REGS'(1);
        end
    end

    assign pending = r_pending;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != REG_ZERO) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_age_valid[i] && (w_age_addr[i] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = w_age_data[i];
                end
            end
        end
    end

endmodule
`default_nettype wire
